// File: rtl/i2s_pkg.sv
// ============================================================================
// Module  : i2s_pkg
// Brief   : Shared constants and helpers for the I2S transmit generator.
// Revision: 1.0
// ============================================================================
`default_nettype none

package i2s_pkg;

  localparam int MODE_I2S      = 0;
  localparam int MODE_RJ       = 1;

  localparam int DEF_BCK_DIV   = 4;
  localparam int DEF_SLOT_BITS = 32;

  // Counter widths are derived per instance from BCK_DIV and 2*SLOT_BITS
  function automatic int ctr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // WS level that marks the left channel
  function automatic logic left_level(input int mode);
    return (mode == MODE_RJ);
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2s_tx_timing.sv
// ============================================================================
// Module  : i2s_tx_timing
// Brief   : BCK/bit counters, registered BCK and WS, frame load strobe.
// Revision: 1.0
// ============================================================================
`default_nettype none

module i2s_tx_timing
  import i2s_pkg::*;
#(
  parameter int SLOT_BITS = DEF_SLOT_BITS,
  parameter int BCK_DIV   = DEF_BCK_DIV,
  parameter int MODE      = MODE_I2S
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_bck,
  output logic o_ws,
  output logic o_load,
  output logic o_bit_tick
);

  localparam int BCKW = ctr_w(BCK_DIV);
  localparam int BITW = ctr_w(2 * SLOT_BITS);

  localparam logic [BCKW-1:0] C_BCK_LAST = BCKW'(BCK_DIV - 1);
  localparam logic [BCKW-1:0] C_BCK_HALF = BCKW'(BCK_DIV / 2);
  localparam logic [BITW-1:0] C_BIT_LAST = BITW'(2 * SLOT_BITS - 1);
  localparam logic [BITW-1:0] C_SLOT     = BITW'(SLOT_BITS);
  localparam logic [BITW-1:0] C_SLOT_M1  = BITW'(SLOT_BITS - 1);

  logic [BCKW-1:0] r_bck_ctr;
  logic [BITW-1:0] r_bit_ctr;
  logic            r_bck;
  logic            r_ws;
  logic            w_bck_wrap;
  logic            w_left;
  logic            w_ws;

  assign w_bck_wrap = (r_bck_ctr == C_BCK_LAST);

  // I2S leads the left MSB by one bit; right-justified aligns WS to the slot
  if (MODE == MODE_RJ) begin : g_rj
    assign w_left = (r_bit_ctr < C_SLOT);
  end else begin : g_i2s
    assign w_left = (r_bit_ctr == C_BIT_LAST) || (r_bit_ctr < C_SLOT_M1);
  end

  assign w_ws = w_left ? left_level(MODE) : ~left_level(MODE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bck_ctr <= '0;
      r_bit_ctr <= '0;
      r_bck     <= 1'b0;
      r_ws      <= ~left_level(MODE);
    end else begin
      r_bck_ctr <= w_bck_wrap ? '0 : r_bck_ctr + 1'b1;
      if (w_bck_wrap) begin
        r_bit_ctr <= (r_bit_ctr == C_BIT_LAST) ? '0 : r_bit_ctr + 1'b1;
      end
      r_bck <= (r_bck_ctr >= C_BCK_HALF);
      r_ws  <= w_ws;
    end
  end

  assign o_bck      = r_bck;
  assign o_ws       = r_ws;
  assign o_bit_tick = (r_bck_ctr == '0);
  assign o_load     = (r_bck_ctr == '0) && (r_bit_ctr == '0);

endmodule

`default_nettype wire

// File: rtl/i2s_tx_gen.sv
// ============================================================================
// Module  : i2s_tx_gen
// Brief   : I2S master transmitter with sample holding register and underrun.
// Revision: 1.0
// ============================================================================
`default_nettype none

module i2s_tx_gen
  import i2s_pkg::*;
#(
  parameter int I2S_DATA_BITS = 16,
  parameter int SLOT_BITS     = DEF_SLOT_BITS,
  parameter int BCK_DIV       = DEF_BCK_DIV,
  parameter int MODE          = MODE_I2S
) (
  input  logic                     AMCLK_i,
  input  logic                     reset_n,
  input  logic [I2S_DATA_BITS-1:0] APDATA_LEFT_i,
  input  logic [I2S_DATA_BITS-1:0] APDATA_RIGHT_i,
  input  logic                     APDATA_VALID_i,
  output logic                     I2S_BCK_o,
  output logic                     I2S_WS_o,
  output logic                     I2S_DATA_o,
  output logic                     FRAME_START_o,
  output logic                     UNDERRUN_o
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;

  logic [I2S_DATA_BITS-1:0] r_hold_l;
  logic [I2S_DATA_BITS-1:0] r_hold_r;
  logic                     r_fresh;
  logic [FRAME_BITS-1:0]    r_shift;
  logic                     r_data;
  logic                     r_fs;
  logic                     r_ur;

  logic                     w_load;
  logic                     w_bit_tick;
  logic [SLOT_BITS-1:0]     w_slot_l;
  logic [SLOT_BITS-1:0]     w_slot_r;
  logic [FRAME_BITS-1:0]    w_frame;

  i2s_tx_timing #(
    .SLOT_BITS (SLOT_BITS),
    .BCK_DIV   (BCK_DIV),
    .MODE      (MODE)
  ) u_timing (
    .clk        (AMCLK_i),
    .rst_n      (reset_n),
    .o_bck      (I2S_BCK_o),
    .o_ws       (I2S_WS_o),
    .o_load     (w_load),
    .o_bit_tick (w_bit_tick)
  );

  // Slot formatting: MSB-aligned with zero fill, or LSB-aligned with sign fill
  if (MODE == MODE_RJ) begin : g_rj_slot
    assign w_slot_l = SLOT_BITS'($signed(r_hold_l));
    assign w_slot_r = SLOT_BITS'($signed(r_hold_r));
  end else begin : g_i2s_slot
    assign w_slot_l = SLOT_BITS'(r_hold_l) << (SLOT_BITS - I2S_DATA_BITS);
    assign w_slot_r = SLOT_BITS'(r_hold_r) << (SLOT_BITS - I2S_DATA_BITS);
  end

  assign w_frame = {w_slot_l, w_slot_r};

  always_ff @(posedge AMCLK_i) begin
    if (!reset_n) begin
      r_hold_l <= '0;
      r_hold_r <= '0;
      r_fresh  <= 1'b0;
      r_shift  <= '0;
      r_data   <= 1'b0;
      r_fs     <= 1'b0;
      r_ur     <= 1'b0;
    end else begin
      r_fs <= w_load;
      r_ur <= w_load & ~r_fresh;

      if (APDATA_VALID_i) begin
        r_hold_l <= APDATA_LEFT_i;
        r_hold_r <= APDATA_RIGHT_i;
      end

      // A strobe coinciding with the load keeps the flag set for next frame
      if (APDATA_VALID_i) begin
        r_fresh <= 1'b1;
      end else if (w_load) begin
        r_fresh <= 1'b0;
      end

      // Bit 0 comes straight from the formatted frame so it leaves with the load
      if (w_load) begin
        r_data  <= w_frame[FRAME_BITS-1];
        r_shift <= {w_frame[FRAME_BITS-2:0], 1'b0};
      end else if (w_bit_tick) begin
        r_data  <= r_shift[FRAME_BITS-1];
        r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
      end
    end
  end

  assign I2S_DATA_o    = r_data;
  assign FRAME_START_o = r_fs;
  assign UNDERRUN_o    = r_ur;

endmodule

`default_nettype wire

// File: tb/tb_i2s_tx_gen.sv
// ============================================================================
// Module  : tb_i2s_tx_gen
// Brief   : Directed self-checking bench for i2s_tx_gen (MODE 0 and MODE 1).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_i2s_tx_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_l;
  logic [15:0] in_r;
  logic        in_v;

  logic bck0, ws0, dat0, fs0, ur0;
  logic bck1, ws1, dat1, fs1, ur1;
  logic sel;
  logic w_bck, w_ws, w_data, w_fs, w_ur;

  int checks   = 0;
  int failures = 0;
  int n;

  logic [63:0] fd;
  logic [63:0] fw;
  logic        fur;
  logic        ffirst;

  always #5 clk = ~clk;

  i2s_tx_gen #(.I2S_DATA_BITS(16), .SLOT_BITS(32), .BCK_DIV(4), .MODE(0)) dut_i2s (
    .AMCLK_i        (clk),
    .reset_n        (rst_n),
    .APDATA_LEFT_i  (in_l),
    .APDATA_RIGHT_i (in_r),
    .APDATA_VALID_i (in_v),
    .I2S_BCK_o      (bck0),
    .I2S_WS_o       (ws0),
    .I2S_DATA_o     (dat0),
    .FRAME_START_o  (fs0),
    .UNDERRUN_o     (ur0)
  );

  i2s_tx_gen #(.I2S_DATA_BITS(16), .SLOT_BITS(32), .BCK_DIV(4), .MODE(1)) dut_rj (
    .AMCLK_i        (clk),
    .reset_n        (rst_n),
    .APDATA_LEFT_i  (in_l),
    .APDATA_RIGHT_i (in_r),
    .APDATA_VALID_i (in_v),
    .I2S_BCK_o      (bck1),
    .I2S_WS_o       (ws1),
    .I2S_DATA_o     (dat1),
    .FRAME_START_o  (fs1),
    .UNDERRUN_o     (ur1)
  );

  assign w_bck  = sel ? bck1 : bck0;
  assign w_ws   = sel ? ws1  : ws0;
  assign w_data = sel ? dat1 : dat0;
  assign w_fs   = sel ? fs1  : fs0;
  assign w_ur   = sel ? ur1  : ur0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [15:0] l, input logic [15:0] r);
    @(posedge clk); #1;
    in_l = l;
    in_r = r;
    in_v = 1'b1;
    @(posedge clk); #1;
    in_v = 1'b0;
  endtask

  // Decode one frame by sampling DATA/WS on every BCK rise; MSB-first in d/w
  task automatic get_frame(input bit skip_wait, output logic [63:0] d,
                           output logic [63:0] w, output logic ur,
                           output logic first);
    int  k;
    int  b;
    logic prev;
    if (!skip_wait) begin
      k = 0;
      do begin
        @(posedge clk); #1;
        k++;
      end while (!w_fs && k < 600);
      if (!w_fs) check("fs_wait", 64'(w_fs), 64'd1);
    end
    ur    = w_ur;
    first = w_data;
    prev  = w_bck;
    d     = '0;
    w     = '0;
    b     = 0;
    k     = 0;
    while (b < 64 && k < 400) begin
      @(posedge clk); #1;
      k++;
      if (w_bck && !prev) begin
        d[63-b] = w_data;
        w[63-b] = w_ws;
        b++;
      end
      prev = w_bck;
    end
    if (b < 64) check("bit_wait", 64'(b), 64'd64);
  endtask

  initial begin
    sel   = 1'b0;
    rst_n = 1'b0;
    in_v  = 1'b0;
    in_l  = 16'h5555;
    in_r  = 16'hAAAA;

    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("rst_bck",   64'(w_bck),  64'd0);
      check("rst_ws",    64'(w_ws),   64'd1);
      check("rst_data",  64'(w_data), 64'd0);
      check("rst_fs",    64'(w_fs),   64'd0);
      check("rst_ur",    64'(w_ur),   64'd0);
      check("rst_ws_rj", 64'(ws1),    64'd0);
      in_v = ~in_v;
    end
    in_v  = 1'b0;
    rst_n = 1'b1;

    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        check("rel_fs", 64'(w_fs), 64'd1);
        check("rel_ur", 64'(w_ur), 64'd1);
      end
    end while (!w_bck && n < 20);
    check("first_rise", 64'(n), 64'd3);

    n = 0;
    do begin @(posedge clk); #1; n++; end while (w_bck && n < 20);
    do begin @(posedge clk); #1; n++; end while (!w_bck && n < 20);
    check("bck_period", 64'(n), 64'd4);

    // MODE 0 basic frame
    drive(16'h8001, 16'h7FFE);
    get_frame(1'b0, fd, fw, fur, ffirst);
    check("f1_left",  {32'd0, fd[63:32]}, 64'h0000_0000_8001_0000);
    check("f1_right", {32'd0, fd[31:0]},  64'h0000_0000_7FFE_0000);
    check("f1_ws",    fw,                 64'h0000_0001_FFFF_FFFE);
    check("f1_ur",    64'(fur),           64'd0);
    check("f1_msb",   64'(ffirst),        64'd1);

    // Starved frame repeats samples; a strobe inside it refills
    fork
      get_frame(1'b0, fd, fw, fur, ffirst);
      begin
        repeat (20) @(posedge clk);
        drive(16'hA5A5, 16'h5A5A);
      end
    join
    check("f2_left",  {32'd0, fd[63:32]}, 64'h0000_0000_8001_0000);
    check("f2_right", {32'd0, fd[31:0]},  64'h0000_0000_7FFE_0000);
    check("f2_ur",    64'(fur),           64'd1);

    get_frame(1'b0, fd, fw, fur, ffirst);
    check("f3_left",  {32'd0, fd[63:32]}, 64'h0000_0000_A5A5_0000);
    check("f3_right", {32'd0, fd[31:0]},  64'h0000_0000_5A5A_0000);
    check("f3_ur",    64'(fur),           64'd0);

    // Strobe coincident with the load edge
    @(posedge clk); #1;
    in_l = 16'h1234;
    in_r = 16'h4321;
    in_v = 1'b1;
    @(posedge clk); #1;
    in_v = 1'b0;
    check("f4_fs", 64'(w_fs), 64'd1);
    get_frame(1'b1, fd, fw, fur, ffirst);
    check("f4_left",  {32'd0, fd[63:32]}, 64'h0000_0000_A5A5_0000);
    check("f4_right", {32'd0, fd[31:0]},  64'h0000_0000_5A5A_0000);
    check("f4_ur",    64'(fur),           64'd1);

    get_frame(1'b0, fd, fw, fur, ffirst);
    check("f5_left",  {32'd0, fd[63:32]}, 64'h0000_0000_1234_0000);
    check("f5_right", {32'd0, fd[31:0]},  64'h0000_0000_4321_0000);
    check("f5_ur",    64'(fur),           64'd0);

    // One-cycle reset in the middle of the right slot
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!w_fs && n < 20);
    check("f6_fs", 64'(w_fs), 64'd1);
    repeat (161) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_rst_bck",  64'(w_bck),  64'd0);
    check("mid_rst_ws",   64'(w_ws),   64'd1);
    check("mid_rst_data", 64'(w_data), 64'd0);
    check("mid_rst_fs",   64'(w_fs),   64'd0);
    check("mid_rst_ur",   64'(w_ur),   64'd0);
    check("mid_rst_wsrj", 64'(ws1),    64'd0);
    @(posedge clk); #1;
    check("post_rst_fs", 64'(w_fs), 64'd1);

    fork
      get_frame(1'b1, fd, fw, fur, ffirst);
      begin
        repeat (20) @(posedge clk);
        drive(16'hFFFE, 16'h0003);
      end
    join
    check("post_rst_data", fd,        64'd0);
    check("post_rst_ur",   64'(fur),  64'd1);

    // MODE 1 instance: right-justified with sign extension
    sel = 1'b1;
    get_frame(1'b0, fd, fw, fur, ffirst);
    check("rj_left",  {32'd0, fd[63:32]}, 64'h0000_0000_FFFF_FFFE);
    check("rj_right", {32'd0, fd[31:0]},  64'h0000_0000_0000_0003);
    check("rj_ws",    fw,                 64'hFFFF_FFFF_0000_0000);
    check("rj_ur",    64'(fur),           64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/i2s_tx_gen.md
Name: i2s_tx_gen

Overview:
- I2S master transmitter in the AMCLK domain; consumes the parallel stereo sample stream (APDATA_LEFT/RIGHT + VALID strobe) produced by the I2S receive/ASRC stage.
- Generates BCK and WS from AMCLK and re-serializes samples for an external DAC/HDMI transmitter I2S input.
- Decouples the sample strobe rate from frame timing through a holding register, with underrun detection.

Parameters:
- I2S_DATA_BITS, 16, sample width.
- SLOT_BITS, 32, BCK periods per channel slot; must be >= I2S_DATA_BITS.
- BCK_DIV, 4, AMCLK cycles per BCK period; must be even and >= 2.
- MODE, 0, 0 = I2S (left when WS=0, MSB one BCK after WS edge); 1 = right-justified (left when WS=1, LSB in last bit of slot).

Ports:
- AMCLK_i  in  1  sole clock.
- reset_n  in  1  synchronous, active-low reset.
- APDATA_LEFT_i  in  I2S_DATA_BITS  signed left sample.
- APDATA_RIGHT_i  in  I2S_DATA_BITS  signed right sample.
- APDATA_VALID_i  in  1  one-cycle strobe; samples valid this cycle.
- I2S_BCK_o  out  1  bit clock, AMCLK/BCK_DIV, 50% duty.
- I2S_WS_o  out  1  word select.
- I2S_DATA_o  out  1  serial data; changes on BCK falling edge.
- FRAME_START_o  out  1  one-cycle pulse aligned with the first bit of the left slot.
- UNDERRUN_o  out  1  one-cycle pulse: frame loaded without a fresh sample.

Behaviour:
- Reset (reset_n low at a clock edge): all counters 0; holding L/R 0; fresh flag 0; shift registers 0. Outputs: BCK 0, WS = right level (1 in MODE 0, 0 in MODE 1), DATA 0, FRAME_START 0, UNDERRUN 0. Reset mid-frame aborts the frame immediately. After release, the frame restarts from counter 0.
- Counters:
  - bck_ctr runs 0..BCK_DIV-1 and wraps.
  - bit_ctr runs 0..2*SLOT_BITS-1 and advances when bck_ctr wraps.
  - Frame = 2*SLOT_BITS*BCK_DIV AMCLK cycles. Defaults give 256 cycles, so fs = AMCLK/256.
- BCK, WS and DATA are registered from the same counter state, so they stay mutually aligned with one cycle of latency.
- BCK = (bck_ctr >= BCK_DIV/2). The falling edge of BCK coincides with a bit boundary.
- Holding register:
  - Written on APDATA_VALID_i and sets the fresh flag.
  - Multiple valids per frame: the last one wins.
- Frame load happens at bit_ctr=0, bck_ctr=0:
  - Shift registers take the holding values as they were before that edge.
  - UNDERRUN pulses if the fresh flag was 0; the previous samples are then repeated.
  - Fresh flag clears, unless VALID is asserted in the same cycle; set wins. A coincident sample is used in the next frame.
- MODE 0 timing:
  - WS=0 for bit_ctr 2*SLOT_BITS-1 and 0..SLOT_BITS-2; WS=1 otherwise. WS therefore leads the MSB by one BCK.
  - Left bits occupy bit_ctr 0..N-1, MSB first; right bits occupy SLOT_BITS..SLOT_BITS+N-1.
  - Remaining slot bits are 0.
- MODE 1 timing:
  - WS=1 for bit_ctr 0..SLOT_BITS-1.
  - Sample bits occupy the last N bits of each slot, MSB first.
  - Leading slot bits are sign extension of the MSB.
- FRAME_START_o pulses in the cycle DATA_o first presents bit_ctr=0.
- Latency: a sample strobed at least one cycle before a frame load appears in that frame.

Decomposition:
- Shared package i2s_pkg holds:
  - MODE_I2S/MODE_RJ constants;
  - left_level(mode) function;
  - ctr width localparams via $clog2 of BCK_DIV and 2*SLOT_BITS.
- One sub-module, i2s_tx_timing: bck_ctr/bit_ctr, BCK/WS generation, and a load strobe.
- The top level holds the holding register, fresh flag, shift/sign-extension logic and output registers.

Test Plan:
- Reset: hold reset_n low 10 cycles with VALID toggling -> BCK=0, WS=1, DATA=0, no pulses. After release, the first BCK rise occurs 3 cycles later and the period is 4 cycles.
- MODE 0, valid L=16'h8001 R=16'h7FFE before a frame -> a BCK-rise-sampling model decodes left slot 8001_0000, right slot 7FFE_0000. WS falls on the BCK fall one bit before the left MSB; FRAME_START aligns with the left MSB.
- No valid during one frame -> exactly one UNDERRUN pulse at the next load; the same L/R is re-sent. A valid in the next frame produces no further pulse.
- VALID coincident with the load cycle (new L=16'h1234) -> the current frame carries the old sample; the following frame carries 1234. No underrun at the following load.
- MODE 1, L=16'hFFFE R=16'h0003, SLOT_BITS=32 -> left slot FFFF_FFFE with WS=1, right slot 0000_0003 with WS=0.
- Assert reset_n low mid-right-slot for 1 cycle -> outputs at reset values the next cycle. Holding is cleared, so the first post-reset frame sends zeros and pulses UNDERRUN.
